// File: rtl/pe_mc_if.sv
// Bundle of the pe_mc data, control and chain signals. The PE is the slave.
// Upstream logic (or a bench) drives the master side.
interface pe_mc_if #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 16,
  parameter int LANES  = 4,
  parameter int LWIDTH = 8
);
  logic                       start;
  logic [LWIDTH-1:0]          cfg_len;
  logic                       en_w;
  logic                       clr_w;
  logic [LANES*IWIDTH-1:0]    wght;
  logic [LANES-1:0]           wght_sign;
  logic [LANES-1:0]           ifm_bit;
  logic [IWIDTH-1:0]          randW;
  logic signed [OWIDTH-1:0]   ofm;
  logic                       ofm_valid;

  logic                       start_d;
  logic                       en_w_d;
  logic                       clr_w_d;
  logic [LANES-1:0]           ifm_bit_d;
  logic [IWIDTH-1:0]          randW_d;
  logic [LANES*IWIDTH-1:0]    wght_d;
  logic [LANES-1:0]           wght_sign_d;
  logic signed [OWIDTH-1:0]   ofm_d;
  logic                       ofm_valid_d;
  logic                       busy;
  logic                       err;

  modport slave (
    input  start, cfg_len, en_w, clr_w, wght, wght_sign, ifm_bit, randW, ofm, ofm_valid,
    output start_d, en_w_d, clr_w_d, ifm_bit_d, randW_d, wght_d, wght_sign_d,
           ofm_d, ofm_valid_d, busy, err
  );

  modport master (
    output start, cfg_len, en_w, clr_w, wght, wght_sign, ifm_bit, randW, ofm, ofm_valid,
    input  start_d, en_w_d, clr_w_d, ifm_bit_d, randW_d, wght_d, wght_sign_d,
           ofm_d, ofm_valid_d, busy, err
  );
endinterface

// File: rtl/pe_mc.sv
// Stochastic-computing MAC processing element with a partial-sum chain.
// Define PE_MC_SAT_EN to saturate the accumulator and output sum instead of wrapping.
module pe_mc #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 16,
  parameter int LANES  = 4,
  parameter int LWIDTH = 8
) (
  input logic   clk,
  input logic   rst,
  pe_mc_if.slave io
);

  typedef enum logic [1:0] {IDLE, MAC, WAIT} state_t;

  state_t                    state;
  logic signed [OWIDTH-1:0]  acc;
  logic [LWIDTH-1:0]         cnt;
  logic                      held;
  logic signed [OWIDTH-1:0]  held_val;
  logic [LANES*IWIDTH-1:0]   wght_q;
  logic [LANES-1:0]          wght_sign_q;
  logic signed [OWIDTH-1:0]  delta;

  function automatic logic signed [OWIDTH-1:0] add_os(
    input logic signed [OWIDTH-1:0] a,
    input logic signed [OWIDTH-1:0] b
  );
    logic signed [OWIDTH:0] s;
    s = {a[OWIDTH-1], a} + {b[OWIDTH-1], b};
`ifdef PE_MC_SAT_EN
    if (s[OWIDTH] != s[OWIDTH-1])
      add_os = s[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
    else
      add_os = s[OWIDTH-1:0];
`else
    add_os = s[OWIDTH-1:0];
`endif
  endfunction

  assign io.busy        = (state != IDLE);
  assign io.wght_d      = wght_q;
  assign io.wght_sign_d = wght_sign_q;

  // Lane products: unary input bit gated by a stochastic weight comparison
  always_comb begin
    delta = '0;
    for (int j = 0; j < LANES; j++) begin
      if (io.ifm_bit[j] && (wght_q[j*IWIDTH +: IWIDTH] > io.randW))
        delta = wght_sign_q[j] ? delta - OWIDTH'(1) : delta + OWIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.start_d   <= 1'b0;
      io.en_w_d    <= 1'b0;
      io.clr_w_d   <= 1'b0;
      io.ifm_bit_d <= '0;
      io.randW_d   <= '0;
    end else begin
      io.start_d   <= io.start;
      io.en_w_d    <= io.en_w;
      io.clr_w_d   <= io.clr_w;
      io.ifm_bit_d <= io.ifm_bit;
      io.randW_d   <= io.randW;
    end
  end

  // Weights are frozen for the whole window; clear always wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wght_q      <= '0;
      wght_sign_q <= '0;
    end else if (io.clr_w) begin
      wght_q      <= '0;
      wght_sign_q <= '0;
    end else if (io.en_w && (state == IDLE)) begin
      wght_q      <= io.wght;
      wght_sign_q <= io.wght_sign;
    end
  end

  // Counter loads cfg_len and counts down through zero, so 0 yields 2^LWIDTH edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      held           <= 1'b0;
      held_val       <= '0;
      io.err         <= 1'b0;
      io.ofm_d       <= '0;
      io.ofm_valid_d <= 1'b0;
    end else begin
      io.ofm_valid_d <= 1'b0;
      case (state)
        IDLE: begin
          if (io.start) begin
            acc   <= '0;
            cnt   <= io.cfg_len;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= add_os(acc, delta);
          cnt <= cnt - LWIDTH'(1);
          if (cnt == LWIDTH'(1))
            state <= WAIT;
        end
        WAIT: begin
          if (held) begin
            io.ofm_d       <= add_os(acc, held_val);
            io.ofm_valid_d <= 1'b1;
            state          <= IDLE;
          end else if (io.ofm_valid) begin
            io.ofm_d       <= add_os(acc, io.ofm);
            io.ofm_valid_d <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A sum arriving in WAIT with an empty holder is consumed directly above
      if (io.ofm_valid) begin
        if (held)
          io.err <= 1'b1;
        else if (state != WAIT) begin
          held     <= 1'b1;
          held_val <= io.ofm;
        end
      end
      if ((state == WAIT) && held)
        held <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_mc.sv
// Bench for pe_mc: hand-computed vector table, randomized windows against an
// arithmetic model, and directed sequences for reset, WAIT, start and holder corners.
module tb_pe_mc;
  localparam int IW = 8;
  localparam int OW = 16;
  localparam int LN = 4;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_mc_if #(.IWIDTH(IW), .OWIDTH(OW), .LANES(LN), .LWIDTH(LW)) bus ();
  pe_mc #(.IWIDTH(IW), .OWIDTH(OW), .LANES(LN), .LWIDTH(LW)) dut (
    .clk(clk), .rst(rst), .io(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [LN*IW-1:0] w;
    logic [LN-1:0]    s;
    logic [LN-1:0]    ifm;
    int               len;
    int               ofm;
    int               exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reduce an unbounded integer to the OW-bit partial-sum range
  function automatic int fit(input int x);
    int hi, lo, m, r;
    hi = (1 << (OW-1)) - 1;
    lo = -(1 << (OW-1));
    m  = 1 << OW;
`ifdef PE_MC_SAT_EN
    r = (x > hi) ? hi : (x < lo) ? lo : x;
`else
    r = x % m;
    if (r > hi) r -= m;
    if (r < lo) r += m;
`endif
    return r;
  endfunction

  // Loads weights, pre-fills the holder, runs one window and reports the chain output
  task automatic run_window(input logic [LN*IW-1:0] w, input logic [LN-1:0] s,
                            input logic [LN-1:0] ifm, input int len, input int ofm,
                            input bit rnd, input string tag,
                            output int got, output int model);
    int n, acc, r;
    logic [LN-1:0] f;
    n   = (len == 0) ? (1 << LW) : len;
    acc = 0;
    bus.wght = w; bus.wght_sign = s; bus.en_w = 1'b1;
    tick;
    bus.en_w = 1'b0;
    chk({tag, ".wght_d"}, bus.wght_d, w);
    bus.ofm = OW'(ofm); bus.ofm_valid = 1'b1;
    tick;
    bus.ofm_valid = 1'b0;
    bus.cfg_len = LW'(len); bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk({tag, ".busy_mac"}, bus.busy, 1);
    for (int k = 0; k < n; k++) begin
      r = rnd ? int'($urandom_range(255)) : (k % 256);
      f = rnd ? LN'($urandom_range(15)) : ifm;
      bus.randW = IW'(r); bus.ifm_bit = f;
      for (int j = 0; j < LN; j++)
        if (f[j] && (int'(w[j*IW +: IW]) > r))
          acc = fit(acc + (s[j] ? -1 : 1));
      tick;
      if (k == 0) begin
        chk({tag, ".randW_d"}, bus.randW_d, r);
        chk({tag, ".ifm_bit_d"}, bus.ifm_bit_d, f);
      end
    end
    bus.randW = '0; bus.ifm_bit = '0;
    chk({tag, ".early_valid"}, bus.ofm_valid_d, 0);
    tick;
    chk({tag, ".valid_at_n1"}, bus.ofm_valid_d, 1);
    got   = $signed(bus.ofm_d);
    model = fit(acc + ofm);
    tick;
    chk({tag, ".valid_pulse"}, bus.ofm_valid_d, 0);
    chk({tag, ".idle"}, bus.busy, 0);
    chk({tag, ".err"}, bus.err, 0);
  endtask

  initial begin
    int got, model;
    logic [LN*IW-1:0] rw;
    logic [LN-1:0] rs;

    bus.start = 0; bus.cfg_len = '0; bus.en_w = 0; bus.clr_w = 0; bus.wght = '0;
    bus.wght_sign = '0; bus.ifm_bit = '0; bus.randW = '0; bus.ofm = '0; bus.ofm_valid = 0;
    rst = 1'b1;
    tick; tick;
    chk("rst.busy", bus.busy, 0);
    chk("rst.err", bus.err, 0);
    chk("rst.ofm_valid_d", bus.ofm_valid_d, 0);
    chk("rst.ofm_d", bus.ofm_d, 0);
    chk("rst.wght_d", bus.wght_d, 0);
    rst = 1'b0;
    tick;

    tbl[0] = '{w: {4{8'd128}}, s: 4'b0000, ifm: 4'b1111, len: 0,  ofm: 100,  exp: 612};
    tbl[1] = '{w: {8'd0, 8'd0, 8'd0, 8'd255}, s: 4'b0001, ifm: 4'b1111, len: 16, ofm: -5, exp: -21};
    tbl[2] = '{w: {8'd255, 8'd0, 8'd20, 8'd10}, s: 4'b0010, ifm: 4'b1011, len: 32, ofm: 7, exp: 29};
    tbl[3] = '{w: {4{8'd0}}, s: 4'b0000, ifm: 4'b1111, len: 5, ofm: -300, exp: -300};
    tbl[4] = '{w: {4{8'd3}}, s: 4'b1111, ifm: 4'b1111, len: 2, ofm: 0, exp: -8};
    tbl[5] = '{w: {8'd1, 8'd9, 8'd5, 8'd200}, s: 4'b1100, ifm: 4'b1110, len: 8, ofm: 1000, exp: 996};
`ifdef PE_MC_SAT_EN
    tbl[6] = '{w: {4{8'd255}}, s: 4'b0000, ifm: 4'b1111, len: 1, ofm: 32767, exp: 32767};
    tbl[7] = '{w: {4{8'd255}}, s: 4'b1111, ifm: 4'b1111, len: 1, ofm: -32768, exp: -32768};
`else
    tbl[6] = '{w: {4{8'd255}}, s: 4'b0000, ifm: 4'b1111, len: 1, ofm: 32767, exp: -32765};
    tbl[7] = '{w: {4{8'd255}}, s: 4'b1111, ifm: 4'b1111, len: 1, ofm: -32768, exp: 32764};
`endif
    for (int i = 0; i < 8; i++) begin
      run_window(tbl[i].w, tbl[i].s, tbl[i].ifm, tbl[i].len, tbl[i].ofm, 1'b0,
                 $sformatf("vec%0d", i), got, model);
      chk($sformatf("vec%0d.ofm_d", i), got, tbl[i].exp);
    end

    for (int i = 0; i < 6; i++) begin
      rw = $urandom; rs = LN'($urandom_range(15));
      run_window(rw, rs, '0, int'($urandom_range(1, 40)), int'($urandom_range(0, 65535)) - 32768,
                 1'b1, $sformatf("rnd%0d", i), got, model);
      chk($sformatf("rnd%0d.ofm_d", i), got, model);
    end

    // Window finishes with an empty holder; the late sum goes straight out
    bus.wght = {4{8'd10}}; bus.wght_sign = '0; bus.en_w = 1'b1;
    tick;
    bus.en_w = 1'b0; bus.ifm_bit = 4'b1111; bus.randW = '0;
    bus.cfg_len = LW'(3); bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) tick;
    for (int k = 0; k < 10; k++) begin
      chk("wait.busy", bus.busy, 1);
      chk("wait.no_valid", bus.ofm_valid_d, 0);
      tick;
    end
    bus.ofm = -16'sd2; bus.ofm_valid = 1'b1;
    tick;
    bus.ofm_valid = 1'b0;
    chk("wait.late_valid", bus.ofm_valid_d, 1);
    chk("wait.late_ofm_d", $signed(bus.ofm_d), 10);
    tick;
    chk("wait.idle", bus.busy, 0);
    chk("wait.err", bus.err, 0);

    // Double fill of the holder, then a start and a weight load while busy
    bus.ofm = 16'sd50; bus.ofm_valid = 1'b1;
    tick;
    bus.ofm = 16'sd77;
    tick;
    bus.ofm_valid = 1'b0;
    chk("ovr.err", bus.err, 1);
    bus.cfg_len = LW'(6); bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    bus.start = 1'b1; bus.en_w = 1'b1; bus.wght = {4{8'd99}}; bus.cfg_len = LW'(40);
    tick;
    bus.start = 1'b0; bus.en_w = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    chk("ovr.busy", bus.busy, 1);
    chk("ovr.no_early", bus.ofm_valid_d, 0);
    tick;
    chk("ovr.valid", bus.ofm_valid_d, 1);
    chk("ovr.first_kept", $signed(bus.ofm_d), 74);
    chk("ovr.wght_locked", bus.wght_d, {4{8'd10}});
    tick;
    chk("ovr.idle", bus.busy, 0);
    chk("ovr.err_sticky", bus.err, 1);
    bus.en_w = 1'b1; bus.clr_w = 1'b1;
    tick;
    bus.en_w = 1'b0; bus.clr_w = 1'b0;
    chk("clr.wins", bus.wght_d, 0);
    chk("clr.clr_w_d", bus.clr_w_d, 1);
    chk("clr.en_w_d", bus.en_w_d, 1);

    // Reset in the middle of a window
    bus.wght = {4{8'd10}}; bus.en_w = 1'b1;
    tick;
    bus.en_w = 1'b0;
    bus.ofm = 16'sd5; bus.ofm_valid = 1'b1;
    tick;
    bus.ofm_valid = 1'b0; bus.randW = 8'd7;
    bus.cfg_len = LW'(20); bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) tick;
    rst = 1'b1;
    #1;
    chk("arst.busy", bus.busy, 0);
    chk("arst.err", bus.err, 0);
    chk("arst.wght_d", bus.wght_d, 0);
    chk("arst.ofm_d", bus.ofm_d, 0);
    chk("arst.randW_d", bus.randW_d, 0);
    chk("arst.ifm_bit_d", bus.ifm_bit_d, 0);
    tick;
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (bus.ofm_valid_d !== 1'b0 || bus.busy !== 1'b0) begin
        chk("arst.no_pulse", {bus.ofm_valid_d, bus.busy}, 0);
        break;
      end
    end
    chk("arst.quiet", {bus.ofm_valid_d, bus.busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
